batpu_control_unit: RTL and testbench

Multi-cycle control FSM for the BatPU2 8-bit core. It decodes the 16-bit instruction word and drives every control input of the core datapath: register write enables, ALU operand select, flag select, PC, call stack and writeback mux. It handshakes with instruction memory and with a variable-latency data memory, and implements HLT with a restart input. It sits between the memories and the datapath, one instance per core.

---
 rtl/batpu_ctrl_pkg.sv | 50 +++++
 rtl/batpu_control_unit.sv | 202 ++++++++++++++++++++
 tb/tb_batpu_control_unit.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/batpu_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// batpu_ctrl_pkg
// Shared types and constants for the BatPU2 control unit.
//   opcode_t   : 4-bit instruction opcode, inst_bus[15:12]
//   state_t    : control FSM states
//   COND_*     : branch condition codes, inst_bus[11:10]
//   WB_*       : writeback mux select values for reg_in_sel
// ---------------------------------------------------------------------------
package batpu_ctrl_pkg;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_HLT = 4'h1,
    OP_ADD = 4'h2,
    OP_SUB = 4'h3,
    OP_NOR = 4'h4,
    OP_AND = 4'h5,
    OP_XOR = 4'h6,
    OP_RSH = 4'h7,
    OP_LDI = 4'h8,
    OP_ADI = 4'h9,
    OP_JMP = 4'hA,
    OP_BRH = 4'hB,
    OP_CAL = 4'hC,
    OP_RET = 4'hD,
    OP_LOD = 4'hE,
    OP_STR = 4'hF
  } opcode_t;

  typedef enum logic [2:0] {
    ST_RST_PC  = 3'd0,
    ST_FETCH   = 3'd1,
    ST_EXEC    = 3'd2,
    ST_MEM     = 3'd3,
    ST_RET_INC = 3'd4,
    ST_HALT    = 3'd5
  } state_t;

  // Branch conditions: bit 1 picks the flag (0 zero, 1 carry),
  // bit 0 inverts it.
  localparam logic [1:0] COND_Z  = 2'b00;
  localparam logic [1:0] COND_NZ = 2'b01;
  localparam logic [1:0] COND_C  = 2'b10;
  localparam logic [1:0] COND_NC = 2'b11;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_IMM  = 2'b01;
  localparam logic [1:0] WB_LOAD = 2'b10;

endpackage

// File: rtl/batpu_control_unit.sv
// ---------------------------------------------------------------------------
// batpu_control_unit
// Multi-cycle control FSM of the BatPU2 8-bit core. Decodes the instruction
// word and drives every datapath control; handshakes with instruction and
// data memory; implements HLT with a run restart.
//
// Parameters
//   HALT_ON_RESET : 1 = go to HALT after the reset PC clear instead of FETCH
// Inputs
//   clk, rst      : core clock; asynchronous active-high reset
//   inst_bus      : instruction word (opcode [15:12], branch cond [11:10])
//   inst_valid    : instruction memory presents the word for the current PC
//   flag_out      : flag selected by flags_sel from the datapath
//   mem_ready     : data memory completes the current access this cycle
//   run           : restart request, honoured only in HALT
// Outputs
//   fetch_req, mem_req, mem_we             : memory requests
//   pc_en, pc_jmp, pc_sync_rst, pc_in_sel  : PC controls
//   cs_en, cs_sel                          : call stack (sel 1 push, 0 pop)
//   rb_a_we, rb_b_we, rb_c_we              : register file write enables
//   alu_b_sel, reg_in_sel                  : operand / writeback muxes
//   flags_we, flags_sel                    : flag register controls
//   halted                                 : FSM is in HALT
//   dbg_state                              : current FSM state
//
// Handshakes: a request (fetch_req / mem_req) is held high and stable until
// the matching completion (inst_valid / mem_ready) is sampled high on a
// rising edge; the transfer happens on that edge and the request is never
// withdrawn before it. Completions outside their request state are ignored.
// ---------------------------------------------------------------------------
module batpu_control_unit
  import batpu_ctrl_pkg::*;
#(
  parameter bit HALT_ON_RESET = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] inst_bus,
  input  logic        inst_valid,
  input  logic        flag_out,
  input  logic        mem_ready,
  input  logic        run,
  output logic        fetch_req,
  output logic        mem_req,
  output logic        mem_we,
  output logic        pc_en,
  output logic        pc_jmp,
  output logic        pc_sync_rst,
  output logic        pc_in_sel,
  output logic        cs_en,
  output logic        cs_sel,
  output logic        rb_a_we,
  output logic        rb_b_we,
  output logic        rb_c_we,
  output logic        alu_b_sel,
  output logic [1:0]  reg_in_sel,
  output logic        flags_we,
  output logic        flags_sel,
  output logic        halted,
  output logic [2:0]  dbg_state
);

  state_t  state_q, state_d;
  // Remembers LOD vs STR across the MEM wait so the access qualifier does
  // not depend on the instruction bus staying stable.
  logic    is_store_q, is_store_d;
  opcode_t op;
  logic [1:0] cond;
  logic    unused_inst_bits;

  assign op   = opcode_t'(inst_bus[15:12]);
  assign cond = inst_bus[11:10];
  assign unused_inst_bits = ^inst_bus[9:0];
  assign dbg_state = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_RST_PC;
      is_store_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_store_q <= is_store_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    is_store_d  = is_store_q;
    fetch_req   = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    pc_en       = 1'b0;
    pc_jmp      = 1'b0;
    pc_sync_rst = 1'b0;
    pc_in_sel   = 1'b0;
    cs_en       = 1'b0;
    cs_sel      = 1'b0;
    rb_a_we     = 1'b0;
    rb_b_we     = 1'b0;
    rb_c_we     = 1'b0;
    alu_b_sel   = 1'b0;
    reg_in_sel  = WB_ALU;
    flags_we    = 1'b0;
    flags_sel   = 1'b0;
    halted      = 1'b0;

    case (state_q)
      ST_RST_PC: begin
        pc_sync_rst = 1'b1;
        state_d     = HALT_ON_RESET ? ST_HALT : ST_FETCH;
      end

      ST_FETCH: begin
        fetch_req = 1'b1;
        if (inst_valid) state_d = ST_EXEC;
      end

      ST_EXEC: begin
        state_d = ST_FETCH;
        case (op)
          OP_NOP: pc_en = 1'b1;
          OP_HLT: state_d = ST_HALT;
          OP_ADD, OP_SUB, OP_NOR, OP_AND, OP_XOR, OP_RSH: begin
            rb_c_we  = 1'b1;
            flags_we = 1'b1;
            pc_en    = 1'b1;
          end
          OP_LDI: begin
            rb_a_we    = 1'b1;
            reg_in_sel = WB_IMM;
            pc_en      = 1'b1;
          end
          OP_ADI: begin
            rb_a_we   = 1'b1;
            alu_b_sel = 1'b1;
            flags_we  = 1'b1;
            pc_en     = 1'b1;
          end
          OP_JMP: begin
            pc_en  = 1'b1;
            pc_jmp = 1'b1;
          end
          OP_BRH: begin
            // cond[1] selects the flag, cond[0] inverts the test.
            flags_sel = cond[1];
            pc_en     = 1'b1;
            pc_jmp    = flag_out ^ cond[0];
          end
          OP_CAL: begin
            cs_en  = 1'b1;
            cs_sel = 1'b1;
            pc_en  = 1'b1;
            pc_jmp = 1'b1;
          end
          OP_RET: begin
            // Pop returns the CAL's own address; RET_INC steps past it.
            cs_en     = 1'b1;
            pc_en     = 1'b1;
            pc_jmp    = 1'b1;
            pc_in_sel = 1'b1;
            state_d   = ST_RET_INC;
          end
          OP_LOD, OP_STR: begin
            is_store_d = (op == OP_STR);
            state_d    = ST_MEM;
          end
          default: state_d = ST_FETCH;
        endcase
      end

      ST_MEM: begin
        mem_req = 1'b1;
        mem_we  = is_store_q;
        if (mem_ready) begin
          pc_en = 1'b1;
          if (!is_store_q) begin
            rb_b_we    = 1'b1;
            reg_in_sel = WB_LOAD;
          end
          state_d = ST_FETCH;
        end
      end

      ST_RET_INC: begin
        pc_en   = 1'b1;
        state_d = ST_FETCH;
      end

      ST_HALT: begin
        halted = 1'b1;
        // Leaving HALT on the same edge makes a held run restart only once.
        if (run) begin
          pc_en   = 1'b1;
          state_d = ST_FETCH;
        end
      end

      default: state_d = ST_RST_PC;
    endcase
  end

endmodule

// File: tb/tb_batpu_control_unit.sv
// ---------------------------------------------------------------------------
// tb_batpu_control_unit
// Directed bench for batpu_control_unit. Each instruction is expanded into
// its expected per-cycle control word timeline, queued, and checked by one
// compare process on every falling edge. A second instance built with
// HALT_ON_RESET=1 shares the inputs and is checked around resets.
// ---------------------------------------------------------------------------
module tb_batpu_control_unit;

  // Control word bit masks (MSB first: fetch_req ... halted).
  localparam logic [17:0] M_FETCH   = 18'h20000;
  localparam logic [17:0] M_MREQ    = 18'h10000;
  localparam logic [17:0] M_MWE     = 18'h08000;
  localparam logic [17:0] M_PCEN    = 18'h04000;
  localparam logic [17:0] M_JMP     = 18'h02000;
  localparam logic [17:0] M_SRST    = 18'h01000;
  localparam logic [17:0] M_PCSEL   = 18'h00800;
  localparam logic [17:0] M_CSEN    = 18'h00400;
  localparam logic [17:0] M_CSSEL   = 18'h00200;
  localparam logic [17:0] M_RBA     = 18'h00100;
  localparam logic [17:0] M_RBB     = 18'h00080;
  localparam logic [17:0] M_RBC     = 18'h00040;
  localparam logic [17:0] M_ALUB    = 18'h00020;
  localparam logic [17:0] M_WB_LOAD = 18'h00010;
  localparam logic [17:0] M_WB_IMM  = 18'h00008;
  localparam logic [17:0] M_FWE     = 18'h00004;
  localparam logic [17:0] M_FSEL    = 18'h00002;
  localparam logic [17:0] M_HALT    = 18'h00001;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [15:0] inst_bus   = 16'h0000;
  logic        inst_valid = 1'b0;
  logic        flag_out   = 1'b0;
  logic        mem_ready  = 1'b0;
  logic        run        = 1'b0;

  logic fetch_req, mem_req, mem_we, pc_en, pc_jmp, pc_sync_rst, pc_in_sel;
  logic cs_en, cs_sel, rb_a_we, rb_b_we, rb_c_we, alu_b_sel;
  logic [1:0] reg_in_sel;
  logic flags_we, flags_sel, halted;
  logic [2:0] unused_dbg_a;

  logic fetch_req_h, mem_req_h, mem_we_h, pc_en_h, pc_jmp_h, pc_sync_rst_h, pc_in_sel_h;
  logic cs_en_h, cs_sel_h, rb_a_we_h, rb_b_we_h, rb_c_we_h, alu_b_sel_h;
  logic [1:0] reg_in_sel_h;
  logic flags_we_h, flags_sel_h, halted_h;
  logic [2:0] unused_dbg_b;

  batpu_control_unit #(.HALT_ON_RESET(1'b0)) dut (
    .clk(clk), .rst(rst), .inst_bus(inst_bus), .inst_valid(inst_valid),
    .flag_out(flag_out), .mem_ready(mem_ready), .run(run),
    .fetch_req(fetch_req), .mem_req(mem_req), .mem_we(mem_we),
    .pc_en(pc_en), .pc_jmp(pc_jmp), .pc_sync_rst(pc_sync_rst), .pc_in_sel(pc_in_sel),
    .cs_en(cs_en), .cs_sel(cs_sel),
    .rb_a_we(rb_a_we), .rb_b_we(rb_b_we), .rb_c_we(rb_c_we),
    .alu_b_sel(alu_b_sel), .reg_in_sel(reg_in_sel),
    .flags_we(flags_we), .flags_sel(flags_sel), .halted(halted),
    .dbg_state(unused_dbg_a)
  );

  batpu_control_unit #(.HALT_ON_RESET(1'b1)) dut_h (
    .clk(clk), .rst(rst), .inst_bus(inst_bus), .inst_valid(inst_valid),
    .flag_out(flag_out), .mem_ready(mem_ready), .run(run),
    .fetch_req(fetch_req_h), .mem_req(mem_req_h), .mem_we(mem_we_h),
    .pc_en(pc_en_h), .pc_jmp(pc_jmp_h), .pc_sync_rst(pc_sync_rst_h), .pc_in_sel(pc_in_sel_h),
    .cs_en(cs_en_h), .cs_sel(cs_sel_h),
    .rb_a_we(rb_a_we_h), .rb_b_we(rb_b_we_h), .rb_c_we(rb_c_we_h),
    .alu_b_sel(alu_b_sel_h), .reg_in_sel(reg_in_sel_h),
    .flags_we(flags_we_h), .flags_sel(flags_sel_h), .halted(halted_h),
    .dbg_state(unused_dbg_b)
  );

  logic [17:0] got, got_h;
  assign got = {fetch_req, mem_req, mem_we, pc_en, pc_jmp, pc_sync_rst, pc_in_sel,
                cs_en, cs_sel, rb_a_we, rb_b_we, rb_c_we, alu_b_sel, reg_in_sel,
                flags_we, flags_sel, halted};
  assign got_h = {fetch_req_h, mem_req_h, mem_we_h, pc_en_h, pc_jmp_h, pc_sync_rst_h,
                  pc_in_sel_h, cs_en_h, cs_sel_h, rb_a_we_h, rb_b_we_h, rb_c_we_h,
                  alu_b_sel_h, reg_in_sel_h, flags_we_h, flags_sel_h, halted_h};

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [17:0] exp_q[$];
  string       tag_q[$];
  logic [17:0] cmp_e;
  string       cmp_t;

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      cmp_e = exp_q.pop_front();
      cmp_t = tag_q.pop_front();
      n_cmp++;
      if (got !== cmp_e) begin
        n_err++;
        $display("FAIL %s: control word got %h expected %h (t=%0t)", cmp_t, got, cmp_e, $time);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got_v, input logic [31:0] exp_v);
    n_cmp++;
    if (got_v !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got_v, exp_v, $time);
    end
  endtask

  // ---------------- model ----------------
  // Control word of the EXEC cycle, straight from the opcode table.
  function automatic logic [17:0] exec_vec(input logic [15:0] instr, input logic fl);
    logic [3:0] o;
    logic [1:0] c;
    o = instr[15:12];
    c = instr[11:10];
    case (o)
      4'h0: return M_PCEN;
      4'h1: return 18'h0;
      4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: return M_RBC | M_FWE | M_PCEN;
      4'h8: return M_RBA | M_WB_IMM | M_PCEN;
      4'h9: return M_RBA | M_ALUB | M_FWE | M_PCEN;
      4'hA: return M_PCEN | M_JMP;
      4'hB: return (c[1] ? M_FSEL : 18'h0) | M_PCEN | (((fl ^ c[0]) == 1'b1) ? M_JMP : 18'h0);
      4'hC: return M_CSEN | M_CSSEL | M_PCEN | M_JMP;
      4'hD: return M_CSEN | M_PCEN | M_JMP | M_PCSEL;
      default: return 18'h0;
    endcase
  endfunction

  // ---------------- driver ----------------
  // Called just after a rising edge: drives the cycle's inputs, queues the
  // control word expected for this cycle, and advances one clock.
  task automatic step(input string tag, input logic [15:0] ib, input logic iv,
                      input logic fl, input logic mr, input logic rn, input logic [17:0] e);
    inst_bus   = ib;
    inst_valid = iv;
    flag_out   = fl;
    mem_ready  = mr;
    run        = rn;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  // Whole-instruction timeline: fetch waits, fetch, exec, then RET_INC or
  // the memory phase. Stray completions are driven where they must be ignored.
  task automatic do_instr(input string tag, input logic [15:0] instr, input logic fl,
                          input int fwait, input int mwait, input logic rn);
    logic [17:0] mwe;
    for (int i = 0; i < fwait; i++) step({tag, "/fetch_wait"}, instr, 1'b0, fl, 1'b1, rn, M_FETCH);
    step({tag, "/fetch"}, instr, 1'b1, fl, 1'b0, rn, M_FETCH);
    step({tag, "/exec"}, instr, 1'b1, fl, 1'b1, rn, exec_vec(instr, fl));
    if (instr[15:12] == 4'hD)
      step({tag, "/ret_inc"}, instr, 1'b1, fl, 1'b1, rn, M_PCEN);
    if (instr[15:12] == 4'hE || instr[15:12] == 4'hF) begin
      mwe = (instr[15:12] == 4'hF) ? M_MWE : 18'h0;
      for (int i = 0; i < mwait; i++)
        step({tag, "/mem_wait"}, instr, 1'b1, fl, 1'b0, rn, M_MREQ | mwe);
      step({tag, "/mem_done"}, instr, 1'b0, fl, 1'b1, rn,
           M_MREQ | mwe | M_PCEN | ((instr[15:12] == 4'hE) ? (M_RBB | M_WB_LOAD) : 18'h0));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk);
    #1;
    // Reset: both builds sit in the PC-clear state.
    chk("reset_h_word", {14'h0, got_h}, {14'h0, M_SRST});
    step("reset", 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, M_SRST);
    step("reset", 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, M_SRST);
    rst = 1'b0;
    step("rst_pc", 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, M_SRST);
    chk("halt_on_reset_word", {14'h0, got_h}, {14'h0, M_HALT});

    // ADD, hand-computed control words.
    step("add/fetch", 16'h2123, 1'b1, 1'b0, 1'b0, 1'b0, 18'h20000);
    step("add/exec",  16'h2123, 1'b1, 1'b0, 1'b0, 1'b0, 18'h04044);

    // LOD with two fetch waits and three memory waits, hand-computed.
    step("lod/fetch_wait", 16'hE120, 1'b0, 1'b0, 1'b1, 1'b0, 18'h20000);
    step("lod/fetch_wait", 16'hE120, 1'b0, 1'b0, 1'b1, 1'b0, 18'h20000);
    step("lod/fetch",      16'hE120, 1'b1, 1'b0, 1'b0, 1'b0, 18'h20000);
    step("lod/exec",       16'hE120, 1'b1, 1'b0, 1'b1, 1'b0, 18'h00000);
    for (int i = 0; i < 3; i++)
      step("lod/mem_wait", 16'hE120, 1'b1, 1'b0, 1'b0, 1'b0, 18'h10000);
    step("lod/mem_done",   16'hE120, 1'b0, 1'b0, 1'b1, 1'b0, 18'h14090);

    // BRH !Z, hand-computed: taken with Z=0, not taken with Z=1.
    step("brh_nz0/fetch", 16'hB410, 1'b1, 1'b0, 1'b0, 1'b0, 18'h20000);
    step("brh_nz0/exec",  16'hB410, 1'b1, 1'b0, 1'b0, 1'b0, 18'h06000);
    step("brh_nz1/fetch", 16'hB410, 1'b1, 1'b1, 1'b0, 1'b0, 18'h20000);
    step("brh_nz1/exec",  16'hB410, 1'b1, 1'b1, 1'b0, 1'b0, 18'h04000);

    // CAL then RET, hand-computed.
    step("cal/fetch", 16'hC020, 1'b1, 1'b0, 1'b0, 1'b0, 18'h20000);
    step("cal/exec",  16'hC020, 1'b1, 1'b0, 1'b0, 1'b0, 18'h06600);
    step("ret/fetch", 16'hD000, 1'b1, 1'b0, 1'b0, 1'b0, 18'h20000);
    step("ret/exec",  16'hD000, 1'b1, 1'b0, 1'b0, 1'b0, 18'h06C00);
    step("ret/inc",   16'hD000, 1'b1, 1'b0, 1'b0, 1'b0, 18'h04000);

    // Model-driven instruction mix.
    do_instr("nop",     16'h0000, 1'b0, 0, 0, 1'b0);
    do_instr("sub",     16'h3456, 1'b1, 1, 0, 1'b0);
    do_instr("nor",     16'h4111, 1'b0, 0, 0, 1'b0);
    do_instr("rsh",     16'h7222, 1'b0, 0, 0, 1'b0);
    do_instr("ldi",     16'h8155, 1'b0, 0, 0, 1'b0);
    do_instr("adi",     16'h9207, 1'b1, 2, 0, 1'b0);
    do_instr("jmp",     16'hA0F0, 1'b0, 0, 0, 1'b0);
    do_instr("brh_z0",  16'hB000, 1'b0, 0, 0, 1'b0);
    do_instr("brh_z1",  16'hB000, 1'b1, 0, 0, 1'b0);
    do_instr("brh_c1",  16'hB800, 1'b1, 0, 0, 1'b0);
    do_instr("brh_c0",  16'hB800, 1'b0, 0, 0, 1'b0);
    do_instr("brh_nc1", 16'hBC00, 1'b1, 0, 0, 1'b0);
    do_instr("brh_nc0", 16'hBC00, 1'b0, 0, 0, 1'b0);
    do_instr("cal2",    16'hC0A0, 1'b0, 0, 0, 1'b0);
    do_instr("ret2",    16'hD000, 1'b1, 1, 0, 1'b0);
    do_instr("str",     16'hF340, 1'b0, 0, 2, 1'b0);
    do_instr("lod0",    16'hE120, 1'b0, 0, 0, 1'b0);

    // HLT: 20 quiet cycles with stray completions, then a run pulse.
    do_instr("hlt", 16'h1000, 1'b0, 0, 0, 1'b0);
    for (int i = 0; i < 20; i++)
      step("hlt/halted", 16'h1000, 1'b1, 1'b0, 1'b1, 1'b0, M_HALT);
    step("hlt/run", 16'h1000, 1'b1, 1'b0, 1'b0, 1'b1, M_HALT | M_PCEN);
    do_instr("after_hlt", 16'h0000, 1'b0, 0, 0, 1'b0);

    // HLT with run held high throughout: exactly one restart.
    do_instr("hlt_run", 16'h1000, 1'b0, 0, 0, 1'b1);
    step("hlt_run/halt", 16'h1000, 1'b1, 1'b0, 1'b0, 1'b1, M_HALT | M_PCEN);
    do_instr("hlt_run/next", 16'h2123, 1'b0, 1, 0, 1'b1);
    do_instr("hlt_run/idle", 16'h0000, 1'b0, 0, 0, 1'b0);

    // STR interrupted by reset while waiting on memory.
    step("str_rst/fetch", 16'hF340, 1'b1, 1'b0, 1'b0, 1'b0, M_FETCH);
    step("str_rst/exec",  16'hF340, 1'b1, 1'b0, 1'b0, 1'b0, 18'h0);
    step("str_rst/mem",   16'hF340, 1'b1, 1'b0, 1'b0, 1'b0, M_MREQ | M_MWE);
    mem_ready = 1'b0;
    chk("str_rst/mem_req_before", {31'h0, mem_req}, 32'h1);
    chk("str_rst/mem_we_before", {31'h0, mem_we}, 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("str_rst/mem_req_async", {31'h0, mem_req}, 32'h0);
    chk("str_rst/pc_sync_rst", {31'h0, pc_sync_rst}, 32'h1);
    chk("str_rst/rb_we", {29'h0, rb_a_we, rb_b_we, rb_c_we}, 32'h0);
    step("str_rst/reset", 16'hF340, 1'b1, 1'b0, 1'b1, 1'b0, M_SRST);
    step("str_rst/reset", 16'hF340, 1'b1, 1'b0, 1'b1, 1'b0, M_SRST);
    chk("str_rst/h_in_reset", {14'h0, got_h}, {14'h0, M_SRST});
    rst = 1'b0;
    step("str_rst/rst_pc", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, M_SRST);
    chk("str_rst/h_lands_halt", {14'h0, got_h}, {14'h0, M_HALT});
    do_instr("post_rst", 16'h0000, 1'b0, 0, 0, 1'b0);

    @(negedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
